// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared widths, saturation limit and FSM states for the Sobel stream path
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int GRAD_W  = 11;
  localparam int SAT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sobel3.sv
// rtl/sobel3.sv - combinational 3x3 Sobel kernel, saturated |gx| + |gy|
module sobel3
  import sobel_pkg::*;
(
  input  logic [PIX_W-1:0] p0,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p5,
  input  logic [PIX_W-1:0] p6,
  input  logic [PIX_W-1:0] p7,
  input  logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] mag
);

  logic signed [GRAD_W-1:0] e0, e1, e2, e3, e5, e6, e7, e8;
  logic signed [GRAD_W-1:0] gx, gy;
  logic        [GRAD_W-1:0] ax, ay;
  logic        [GRAD_W:0]   sum;

  // Zero-extend into the signed gradient width; 4*255 still fits in 11 bits signed.
  assign e0 = $signed({{(GRAD_W-PIX_W){1'b0}}, p0});
  assign e1 = $signed({{(GRAD_W-PIX_W){1'b0}}, p1});
  assign e2 = $signed({{(GRAD_W-PIX_W){1'b0}}, p2});
  assign e3 = $signed({{(GRAD_W-PIX_W){1'b0}}, p3});
  assign e5 = $signed({{(GRAD_W-PIX_W){1'b0}}, p5});
  assign e6 = $signed({{(GRAD_W-PIX_W){1'b0}}, p6});
  assign e7 = $signed({{(GRAD_W-PIX_W){1'b0}}, p7});
  assign e8 = $signed({{(GRAD_W-PIX_W){1'b0}}, p8});

  assign gx = (e2 + (e5 <<< 1) + e8) - (e0 + (e3 <<< 1) + e6);
  assign gy = (e0 + (e1 <<< 1) + e2) - (e6 + (e7 <<< 1) + e8);

  assign ax  = gx[GRAD_W-1] ? GRAD_W'(-gx) : GRAD_W'(gx);
  assign ay  = gy[GRAD_W-1] ? GRAD_W'(-gy) : GRAD_W'(gy);
  assign sum = {1'b0, ax} + {1'b0, ay};

  assign mag = (sum > (GRAD_W+1)'(SAT_MAX)) ? PIX_W'(SAT_MAX) : sum[PIX_W-1:0];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// rtl/sobel_stream_ctrl.sv - line-buffered raster controller feeding sobel3 onto a valid/ready stream
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eol,
  output logic             busy,
  output logic             frame_done,
  output logic             sof_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t state, state_nxt;

  logic [CW-1:0]    col, c_eff;
  logic [RW-1:0]    row, r_eff;
  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] up2, up1;
  logic [PIX_W-1:0] kmag;
  logic             accept, proc, produce, last_px;

  // Two retained window columns per row: [0] = c-2, [1] = c-1; the new column is combinational.
  logic [PIX_W-1:0] wt [2];
  logic [PIX_W-1:0] wm [2];
  logic [PIX_W-1:0] wb [2];

  assign in_ready = (state != DONE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign proc     = accept && ((state == RUN) || in_sof);

  // A start-of-frame pixel is always position (0,0), even when it interrupts a frame.
  assign c_eff   = in_sof ? '0 : col;
  assign r_eff   = in_sof ? '0 : row;
  assign up2     = lb1[c_eff];
  assign up1     = lb0[c_eff];
  assign last_px = (r_eff == ROW_LAST) && (c_eff == COL_LAST);
  assign produce = proc && (r_eff >= RW'(2)) && (c_eff >= CW'(2));

  sobel3 u_kernel (
    .p0  (wt[0]),
    .p1  (wt[1]),
    .p2  (up2),
    .p3  (wm[0]),
    .p5  (up1),
    .p6  (wb[0]),
    .p7  (wb[1]),
    .p8  (in_pixel),
    .mag (kmag)
  );

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (accept && in_sof) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (proc && last_px) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (proc) begin
      if (c_eff == COL_LAST) begin
        col <= '0;
        row <= (r_eff == ROW_LAST) ? '0 : r_eff + 1'b1;
      end else begin
        col <= c_eff + 1'b1;
        row <= r_eff;
      end
    end
  end

  // Line buffers carry no reset; stale contents only ever reach border positions that emit nothing.
  always_ff @(posedge clk) begin
    if (proc) begin
      lb1[c_eff] <= lb0[c_eff];
      lb0[c_eff] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        wt[i] <= '0;
        wm[i] <= '0;
        wb[i] <= '0;
      end
    end else if (proc) begin
      wt[0] <= wt[1];
      wm[0] <= wm[1];
      wb[0] <= wb[1];
      wt[1] <= up2;
      wm[1] <= up1;
      wb[1] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      sof_err <= accept && in_sof && (state == RUN);
      if (produce) begin
        out_valid <= 1'b1;
        out_pixel <= kmag;
        out_sof   <= (r_eff == RW'(2)) && (c_eff == CW'(2));
        out_eol   <= (c_eff == COL_LAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// tb/tb_sobel_stream_ctrl.sv - directed scoreboard bench for sobel_stream_ctrl on an 8x6 frame
module tb_sobel_stream_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = '0;
  logic       in_sof = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pixel;
  logic       out_sof, out_eol, busy, frame_done, sof_err;

  int         nvec = 0;
  int         nerr = 0;
  int         nout = 0;
  int         ndone = 0;
  logic [9:0] sbq[$];
  int         mimg[H][W];
  bit         bp = 0;
  int         bp_cnt = 0;
  bit         stall_prev = 0;
  logic [7:0] stall_pix;

  always #5 clk = ~clk;

  sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .busy       (busy),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_at(input int r, input int c);
    int gx, gy, m;
    gx = (mimg[r-2][c] + 2*mimg[r-1][c] + mimg[r][c]) - (mimg[r-2][c-2] + 2*mimg[r-1][c-2] + mimg[r][c-2]);
    gy = (mimg[r-2][c-2] + 2*mimg[r-2][c-1] + mimg[r-2][c]) - (mimg[r][c-2] + 2*mimg[r][c-1] + mimg[r][c]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic logic [7:0] pix(input int kind, input int r, input int c);
    case (kind)
      0: return 8'd100;
      1: return (c < 4) ? 8'd0 : 8'd255;
      2: return 8'(10 * c);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Downstream ready: held high, or 10 low cycles followed by toggling when bp is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp) begin
        out_ready = (bp_cnt < 10) ? 1'b0 : ~out_ready;
        bp_cnt++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_pixel", out_pixel, stall_pix);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        stall_prev = 1;
        stall_pix  = out_pixel;
      end else begin
        stall_prev = 0;
      end
      if (out_valid && out_ready) begin
        nout++;
        if (sbq.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          e = sbq.pop_front();
          check("out_pixel", out_pixel, e[7:0]);
          check("out_sof", out_sof, e[8]);
          check("out_eol", out_eol, e[9]);
        end
      end
      if (frame_done) begin
        ndone++;
        check("done_with_valid", out_valid, 1);
        check("done_with_eol", out_eol, 1);
      end
    end
  end

  task automatic drive(input logic [7:0] p, input logic s);
    bit ok = 0;
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = s;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!ok) check("accept_timeout", in_ready, 1);
  endtask

  task automatic send_pix(input int r, input int c, input logic [7:0] p, input logic s);
    logic [9:0] e;
    mimg[r][c] = p;
    if (r >= 2 && c >= 2) begin
      e[7:0] = 8'(exp_at(r, c));
      e[8]   = (r == 2 && c == 2);
      e[9]   = (c == W - 1);
      sbq.push_back(e);
    end
    drive(p, s);
  endtask

  task automatic send_frame(input int kind);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pix(r, c, pix(kind, r, c), (r == 0 && c == 0));
        if (r == 0 && c == 0) check("busy_in_run", busy, 1);
        if (kind == 3 && r == 2 && c == 3) begin
          bp_cnt = 0;
          bp = 1;
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(posedge clk);
    bp = 0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 16'(sbq.size()), 0);
  endtask

  initial begin
    int n0, d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sof_err", sof_err, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant frame: all outputs zero, one frame_done, DONE bubble.
    n0 = nout;
    d0 = ndone;
    send_frame(0);
    check("done_pulse", frame_done, 1);
    check("done_in_ready", in_ready, 0);
    check("done_busy", busy, 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", frame_done, 0);
    drain();
    check("const_out_count", 16'(nout - n0), 24);
    check("const_done_count", 16'(ndone - d0), 1);

    // Vertical step and horizontal ramp.
    send_frame(1);
    drain();
    n0 = nout;
    send_frame(2);
    drain();
    check("ramp_out_count", 16'(nout - n0), 24);

    // Random frame with downstream backpressure mid-frame.
    n0 = nout;
    send_frame(3);
    drain();
    check("bp_out_count", 16'(nout - n0), 24);

    // Restart of a frame by in_sof at (3,1).
    n0 = nout;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++)
        send_pix(r, c, pix(4, r, c), (r == 0 && c == 0));
    send_pix(3, 0, pix(4, 3, 0), 1'b0);
    send_pix(0, 0, pix(4, 0, 0), 1'b1);
    check("sof_err_pulse", sof_err, 1);
    check("sof_err_busy", busy, 1);
    send_pix(0, 1, pix(4, 0, 1), 1'b0);
    check("sof_err_one_cycle", sof_err, 0);
    for (int i = 2; i < W * H; i++) send_pix(i / W, i % W, pix(4, i / W, i % W), 1'b0);
    drain();
    check("restart_out_count", 16'(nout - n0), 30);

    // Reset mid-frame with an output pending.
    for (int i = 0; i < 3 * W + 5; i++) send_pix(i / W, i % W, pix(5, i / W, i % W), (i == 0));
    check("pending_before_rst", out_valid, 1);
    rst_n = 1'b0;
    #1;
    sbq.delete();
    check("arst_out_valid", out_valid, 0);
    check("arst_out_pixel", out_pixel, 0);
    check("arst_out_sof", out_sof, 0);
    check("arst_out_eol", out_eol, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = nout;
    for (int i = 0; i < 3 * W; i++) drive(8'($urandom_range(0, 255)), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_busy", busy, 0);
    check("idle_no_out", 16'(nout - n0), 0);

    // Clean frame after reset.
    send_frame(6);
    drain();
    check("total_frames", 16'(ndone), 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
